// File: rtl/time_keeper_if.sv
// time_keeper_if: run/load controls and the time/strobe outputs of the
// time-of-day counter. The master side drives run and loads; the slave side
// is the counter itself.
// Optional build macro: H12_DISPLAY_EN adds the pm flag.
interface time_keeper_if;
  logic       run;
  logic       load_valid;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;
  logic       min_tick;
  logic       day_tick;
  logic       load_err;
`ifdef H12_DISPLAY_EN
  logic       pm;
`endif

  modport master (
    output run, load_valid, load_hour, load_min,
    input  hours, minutes, seconds, sec_tick, min_tick, day_tick, load_err
`ifdef H12_DISPLAY_EN
    , input pm
`endif
  );

  modport slave (
    input  run, load_valid, load_hour, load_min,
    output hours, minutes, seconds, sec_tick, min_tick, day_tick, load_err
`ifdef H12_DISPLAY_EN
    , output pm
`endif
  );
endinterface

// File: rtl/time_keeper.sv
// time_keeper: divides clk down to a 1 Hz advance and keeps hh:mm:ss in
// binary, with single-cycle sec/min/day strobes for the alarm watchman and a
// range-checked time-set load. An accepted load beats a coincident advance.
// Optional build macro: H12_DISPLAY_EN presents hours as 1..12 plus a pm flag;
// internal counting and loads stay 24-hour.
module time_keeper #(
  parameter int CLK_HZ = 50000000,
  parameter int PRE_W  = 26
) (
  input  logic           clk,
  input  logic           rst_n,
  time_keeper_if.slave   tk
);

  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             sec_tick_d, min_tick_d, day_tick_d, load_err_d;
  logic             terminal, load_ok;

  assign terminal = tk.run && (pre_q == PRE_TC);
  assign load_ok  = tk.load_valid && (tk.load_hour <= 5'd23) && (tk.load_min <= 6'd59);

`ifdef H12_DISPLAY_EN
  // Map the internal 24-hour value onto the 12-hour face (0 -> 12).
  function automatic logic [4:0] to_12h(input logic [4:0] h);
    if (h == 5'd0)       return 5'd12;
    else if (h > 5'd12)  return h - 5'd12;
    else                 return h;
  endfunction
`endif

  // Next-state: load takes priority, otherwise prescale and cascade the advance.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    pre_d      = pre_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    day_tick_d = 1'b0;
    load_err_d = 1'b0;

    if (load_ok) begin
      hour_d     = tk.load_hour;
      min_d      = tk.load_min;
      sec_d      = 6'd0;
      pre_d      = '0;
      min_tick_d = 1'b1;
    end else begin
      load_err_d = tk.load_valid;
      if (tk.run) begin
        pre_d = terminal ? '0 : pre_q + 1'b1;
      end
      if (terminal) begin
        sec_tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d      = 6'd0;
          min_tick_d = 1'b1;
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            if (hour_q == 5'd23) begin
              hour_d     = 5'd0;
              day_tick_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      hour_q      <= 5'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      tk.minutes  <= 6'd0;
      tk.seconds  <= 6'd0;
      tk.sec_tick <= 1'b0;
      tk.min_tick <= 1'b0;
      tk.day_tick <= 1'b0;
      tk.load_err <= 1'b0;
`ifdef H12_DISPLAY_EN
      tk.hours    <= 5'd12;
      tk.pm       <= 1'b0;
`else
      tk.hours    <= 5'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pre_q       <= pre_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tk.minutes  <= min_d;
      tk.seconds  <= sec_d;
      tk.sec_tick <= sec_tick_d;
      tk.min_tick <= min_tick_d;
      tk.day_tick <= day_tick_d;
      tk.load_err <= load_err_d;
`ifdef H12_DISPLAY_EN
      tk.hours    <= to_12h(hour_d);
      tk.pm       <= (hour_d >= 5'd12);
`else
      tk.hours    <= hour_d;
`endif
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed stimulus for time_keeper at CLK_HZ=4. Each
// stimulus step pushes the strobe events it should cause (cycle, pulses,
// time) into a scoreboard queue; a monitor pops and compares whenever any
// strobe is high and flags events that never arrived.
module tb_time_keeper;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  time_keeper_if tk ();

  time_keeper #(.CLK_HZ(4), .PRE_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tk    (tk.slave)
  );

  // p = {sec_tick, min_tick, day_tick, load_err}; h is the 24-hour value.
  typedef struct {
    int       cyc;
    logic [3:0] p;
    int       h;
    int       m;
    int       s;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_hours(input int h24);
`ifdef H12_DISPLAY_EN
    if (h24 == 0) return 12;
    if (h24 > 12) return h24 - 12;
    return h24;
`else
    return h24;
`endif
  endfunction

  task automatic push(input int c, input logic [3:0] p, input int h, input int m, input int s);
    exp_t e;
    e.cyc = c; e.p = p; e.h = h; e.m = m; e.s = s;
    sb.push_back(e);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_load(input int h, input int m);
    tk.load_valid = 1'b1;
    tk.load_hour  = 5'(h);
    tk.load_min   = 6'(m);
    @(negedge clk);
    tk.load_valid = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hours"}, tk.hours, exp_hours(h));
    check({tag, "_minutes"}, tk.minutes, m);
    check({tag, "_seconds"}, tk.seconds, s);
    check({tag, "_pulses"}, {tk.sec_tick, tk.min_tick, tk.day_tick, tk.load_err}, 0);
`ifdef H12_DISPLAY_EN
    check({tag, "_pm"}, tk.pm, (h >= 12) ? 1 : 0);
`endif
  endtask

  // Monitor: compare every strobe cycle against the head of the scoreboard.
  initial begin
    exp_t e;
    logic [3:0] p;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_event_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      p = {tk.sec_tick, tk.min_tick, tk.day_tick, tk.load_err};
      if (p != 4'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", p, 0);
        end else begin
          e = sb.pop_front();
          check("ev_cycle", cyc, e.cyc);
          check("ev_pulses", p, e.p);
          check("ev_hours", tk.hours, exp_hours(e.h));
          check("ev_minutes", tk.minutes, e.m);
          check("ev_seconds", tk.seconds, e.s);
`ifdef H12_DISPLAY_EN
          check("ev_pm", tk.pm, (e.h >= 12) ? 1 : 0);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int c0, c, t, r;
    rst_n         = 1'b0;
    tk.run        = 1'b0;
    tk.load_valid = 1'b0;
    tk.load_hour  = 5'd0;
    tk.load_min   = 6'd0;
    repeat (2) @(negedge clk);
    check_time("reset", 0, 0, 0);

    // First ticks after release: CLK_HZ cycles after run rises.
    rst_n  = 1'b1;
    c0     = cyc;
    tk.run = 1'b1;
    for (int k = 1; k <= 3; k++) push(c0 + 4 * k, 4'b1000, 0, 0, k);
    goto_cyc(c0 + 12);

    // Load 23:59 and roll through midnight at the 60th advance.
    c = cyc;
    push(c + 1, 4'b0100, 23, 59, 0);
    for (int k = 1; k <= 59; k++) push(c + 1 + 4 * k, 4'b1000, 23, 59, k);
    push(c + 241, 4'b1110, 0, 0, 0);
    push(c + 245, 4'b1000, 0, 0, 1);
    do_load(23, 59);
    goto_cyc(c + 245);

    // Rejected loads (hour 24, then minute 60) leave counting untouched.
    t = cyc;
    push(t + 2, 4'b0001, 0, 0, 1);
    push(t + 4, 4'b1000, 0, 0, 2);
    push(t + 6, 4'b0001, 0, 0, 2);
    push(t + 8, 4'b1000, 0, 0, 3);
    goto_cyc(t + 1);
    do_load(24, 10);
    goto_cyc(t + 5);
    do_load(5, 60);

    // Load 07:30 coincident with a terminal count: advance is discarded.
    push(t + 12, 4'b0100, 7, 30, 0);
    push(t + 16, 4'b1000, 7, 30, 1);
    push(t + 30, 4'b1000, 7, 30, 2);
    goto_cyc(t + 11);
    do_load(7, 30);

    // Freeze for 10 cycles with the prescaler at 1; resume from there.
    goto_cyc(t + 17);
    tk.run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0 || i == 9) check_time("frozen", 7, 30, 1);
    end
    tk.run = 1'b1;

    // Back-to-back loads 00:05 then 13:00; the last one holds.
    push(t + 32, 4'b0100, 0, 5, 0);
    push(t + 33, 4'b0100, 13, 0, 0);
    push(t + 37, 4'b1000, 13, 0, 1);
    goto_cyc(t + 31);
    tk.load_valid = 1'b1;
    tk.load_hour  = 5'd0;
    tk.load_min   = 6'd5;
    @(negedge clk);
    tk.load_hour  = 5'd13;
    tk.load_min   = 6'd0;
    @(negedge clk);
    tk.load_valid = 1'b0;

    // Reset mid-count clears at once; first tick CLK_HZ cycles after release.
    goto_cyc(t + 38);
    rst_n = 1'b0;
    #1;
    check_time("midreset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push(r + 4, 4'b1000, 0, 0, 1);
    goto_cyc(r + 6);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Time-of-day counter directly upstream of the alarm watchman stage.
- Divides the system clock to a 1 Hz tick and keeps hours/minutes/seconds in binary.
- Emits single-cycle tick strobes so the watchman can compare against the alarm time exactly once per minute.
- Accepts a user time-set load with range checking.

Parameters:
- CLK_HZ, 50000000, system clock frequency; prescaler terminal count is CLK_HZ-1. Must be ≥ 2; benches use 4.
- PRE_W, 26, prescaler counter width; must satisfy 2^PRE_W > CLK_HZ-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = time advances; 0 = prescaler and time frozen.
- load_valid  in  1  single-cycle request to load time.
- load_hour  in  5  hour to load, 0..23.
- load_min  in  6  minute to load, 0..59.
- hours  out  5  current hour, 0..23.
- minutes  out  6  current minute, 0..59.
- seconds  out  6  current second, 0..59.
- sec_tick  out  1  one-cycle pulse when seconds advance.
- min_tick  out  1  one-cycle pulse when minutes advance, including after a load.
- day_tick  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async assert, sync release): prescaler=0, hours/minutes/seconds=0, all pulse outputs 0.
- All outputs are registered.
- Prescaler:
  - When run=1, increments every cycle.
  - At CLK_HZ-1 it wraps to 0 and an internal advance occurs in the same cycle.
  - When run=0, the prescaler holds.
- Advance (registered; new values and pulses visible on the cycle after the terminal count):
  - seconds+1 and sec_tick=1.
  - If seconds was 59: seconds=0, minutes+1, min_tick=1.
  - If minutes was 59: minutes=0, hours+1.
  - If hours was 23: hours=0, day_tick=1.
  - All pulses from one advance coincide in the same cycle.
- Load acceptance:
  - A load is accepted when load_valid=1, load_hour≤23 and load_min≤59.
  - Next cycle: hours=load_hour, minutes=load_min, seconds=0, prescaler=0, min_tick=1.
  - An accepted load does not produce sec_tick or day_tick.
  - Loads are accepted regardless of run.
- Load rejection:
  - A load with out-of-range values is rejected.
  - Time and prescaler are unchanged and counting continues normally.
  - load_err=1 for exactly one cycle.
- Priority: an accepted load in the same cycle as a terminal prescale count wins. The advance is discarded, and the only pulse is min_tick from the load.
- Back-to-back loads: each is evaluated independently; the last accepted load determines the state.
- Pulses:
  - Each pulse is high for exactly one cycle.
  - Pulses are never stretched.
  - Pulses are 0 in every cycle without an event.
- Reset mid-count: all state clears immediately. The first sec_tick after release comes CLK_HZ cycles after the first cycle with run=1.

Optional Feature:
- Macro: H12_DISPLAY_EN.
- When defined:
  - Adds output pm (1 bit): 1 when internal hour ≥ 12.
  - hours port presents the 12-hour value 1..12 (internal 0 -> 12, 13..23 -> 1..11).
  - Internal counting, loads (still 24-hour), ticks and range checks are unchanged.
  - pm resets to 0, and hours reads 12 after reset.
- When not defined: no pm port, and hours is the 24-hour value.

Test Plan:
- Reset then run=1 with CLK_HZ=4 -> first sec_tick 4 cycles after release. seconds=1 in the same cycle as the pulse; then one sec_tick every 4 cycles.
- Load 23:59 and run 60 ticks -> at the 60th advance, hours=0, minutes=0, seconds=0, with sec_tick, min_tick and day_tick all high together for one cycle.
- load_hour=24, load_min=10 -> load_err pulses once; time and prescaler continue uninterrupted; no min_tick.
- Load 07:30 timed to coincide with a terminal prescale count -> next cycle shows 07:30:00 with min_tick=1 and sec_tick=0; the next sec_tick arrives 4 cycles later.
- run=0 for 10 cycles mid-count -> outputs frozen, no pulses; resume continues from the held prescaler value.
- With H12_DISPLAY_EN: load 00:05 -> hours=12, pm=0. Load 13:00 -> hours=1, pm=1.
